// File: rtl/issue_queue_dual.sv
// Dual-ported in-order issue queue between decode and the issue/EX stage.
// Decode writes up to two packets per cycle. The two oldest entries are
// presented on o_set1/o_set2, and up to two of them issue as a pair per cycle.

package issue_queue_dual_pkg;

  // Decoded packet as carried from decode to the issue/EX stage.
  typedef struct packed {
    logic        o_valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [2:0]  ldst_type;
    logic [2:0]  br_type;
  } PC_set;

endpackage

// Handshake:
// - A packet in in_set1 is taken at the clock edge when in_ready=1 and
//   in_valid[0]=1.
// - in_set2 is taken only together with in_set1 (in_valid=2'b11).
// - in_valid=2'b10 is ignored.
// - in_ready depends only on the registered occupancy, so a pop in the same
//   cycle never makes room for a push.
// - Downstream consumes issue_cnt packets at the next edge. No ready signal
//   comes back from downstream: stall and flush hold issue_cnt at 0.
module issue_queue_dual
  import issue_queue_dual_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       in_valid,
  input  PC_set            in_set1,
  input  PC_set            in_set2,
  output logic             in_ready,
  input  logic             flush,
  input  logic             stall,
  output PC_set            o_set1,
  output PC_set            o_set2,
  output logic [1:0]       issue_cnt,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  PC_set            mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       n_push;
  PC_set            e1;
  PC_set            e2;
  logic             has1;
  logic             has2;
  logic             raw_hazard;
  logic             both_mem;
  logic             e1_branch;
  logic             pair_ok;

  // The stored valid flag is superseded by the occupancy-derived one on output.
  logic unused_valid_bits;
  assign unused_valid_bits = e1.o_valid ^ e2.o_valid;

  assign head_p1  = head + PTR_W'(1);
  assign tail_p1  = tail + PTR_W'(1);
  assign count    = count_q;
  // Two free slots are needed so a pair can always be accepted.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  // Number of packets accepted at the next edge.
  always_comb begin
    n_push = 2'd0;
    if (in_ready) begin
      case (in_valid)
        2'b11:   n_push = 2'd2;
        2'b01:   n_push = 2'd1;
        default: n_push = 2'd0;
      endcase
    end
  end

  assign e1   = mem[head];
  assign e2   = mem[head_p1];
  assign has1 = (count_q >= CNT_W'(1));
  assign has2 = (count_q >= CNT_W'(2));

  // Pairing rules: no RAW between the two entries, at most one memory op,
  // and the older entry must not be a branch.
  always_comb begin
    raw_hazard = e1.rf_we && (e1.rf_rd != 5'd0) &&
                 ((e1.rf_rd == e2.rf_raddr1) || (e1.rf_rd == e2.rf_raddr2));
    both_mem   = (e1.ldst_type != 3'd0) && (e2.ldst_type != 3'd0);
    e1_branch  = (e1.br_type != 3'd0);
    pair_ok    = has2 && !raw_hazard && !both_mem && !e1_branch;
  end

  // Present the head entries; an entry that is not valid shows as all zeros.
  always_comb begin
    o_set1 = '0;
    o_set2 = '0;
    if (has1) begin
      o_set1         = e1;
      o_set1.o_valid = 1'b1;
    end
    if (pair_ok) begin
      o_set2         = e2;
      o_set2.o_valid = 1'b1;
    end
  end

  // Number of packets consumed at the next edge; frozen by stall or flush.
  always_comb begin
    issue_cnt = 2'd0;
    if (!(stall || flush)) begin
      issue_cnt = {1'b0, has1} + {1'b0, pair_ok};
    end
  end

  // Pointer and occupancy update. Flush empties the queue and drops that cycle's push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(issue_cnt);
      tail    <= tail + PTR_W'(n_push);
      count_q <= count_q + CNT_W'(n_push) - CNT_W'(issue_cnt);
    end
  end

  // Entry storage. It needs no reset because the pointers define what is live.
  always_ff @(posedge clk) begin
    if (!flush && (n_push != 2'd0)) begin
      mem[tail] <= in_set1;
    end
    if (!flush && (n_push == 2'd2)) begin
      mem[tail_p1] <= in_set2;
    end
  end

endmodule

// File: tb/tb_issue_queue_dual.sv
// Bench for issue_queue_dual. The reference is a packet queue that
// applies the pairing, issue and acceptance rules directly to its
// first two entries.
module tb_issue_queue_dual;
  import issue_queue_dual_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SET_W = $bits(PC_set);

  logic             clk;
  logic             rstn;
  logic [1:0]       in_valid;
  PC_set            in_set1;
  PC_set            in_set2;
  logic             in_ready;
  logic             flush;
  logic             stall;
  PC_set            o_set1;
  PC_set            o_set2;
  logic [1:0]       issue_cnt;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;
  int pc_seq = 0;

  logic [SET_W-1:0] exp_q[$];

  issue_queue_dual #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_set1   (in_set1),
    .in_set2   (in_set2),
    .in_ready  (in_ready),
    .flush     (flush),
    .stall     (stall),
    .o_set1    (o_set1),
    .o_set2    (o_set2),
    .issue_cnt (issue_cnt),
    .count     (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic PC_set mk(input logic we, input logic [4:0] rd,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [2:0] ld, input logic [2:0] br);
    PC_set p;
    p.o_valid   = 1'b1;
    p.pc        = 32'(pc_seq);
    pc_seq++;
    p.imm       = $urandom;
    p.alu_op    = 4'($urandom_range(0, 15));
    p.rf_we     = we;
    p.rf_rd     = rd;
    p.rf_raddr1 = r1;
    p.rf_raddr2 = r2;
    p.ldst_type = ld;
    p.br_type   = br;
    return p;
  endfunction

  function automatic PC_set rnd_pkt();
    logic [2:0] ld;
    logic [2:0] br;
    ld = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    br = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    return mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ld, br);
  endfunction

  // driver + scoreboard: one clock cycle of stimulus, checked against the model
  task automatic step(input logic [1:0] v, input PC_set a, input PC_set b,
                      input logic st, input logic fl);
    PC_set e1;
    PC_set e2;
    PC_set x1;
    PC_set x2;
    int    n;
    int    pops;
    logic  pair;
    logic  ready;
    @(negedge clk);
    in_valid = v;
    in_set1  = a;
    in_set2  = b;
    stall    = st;
    flush    = fl;
    #1;
    n    = exp_q.size();
    x1   = '0;
    x2   = '0;
    pair = 1'b0;
    if (n >= 1) begin
      e1 = exp_q[0];
      x1 = e1;
      x1.o_valid = 1'b1;
    end
    if (n >= 2) begin
      e2 = exp_q[1];
      pair = !(e1.rf_we && e1.rf_rd != 0 &&
               (e1.rf_rd == e2.rf_raddr1 || e1.rf_rd == e2.rf_raddr2)) &&
             !(e1.ldst_type != 0 && e2.ldst_type != 0) &&
             (e1.br_type == 0);
      if (pair) begin
        x2 = e2;
        x2.o_valid = 1'b1;
      end
    end
    pops  = (st || fl) ? 0 : ((n >= 1) ? 1 : 0) + (pair ? 1 : 0);
    ready = (DEPTH - n) >= 2;
    check("count",     128'(count),     128'(n));
    check("in_ready",  128'(in_ready),  128'(ready));
    check("o_set1",    128'(o_set1),    128'(x1));
    check("o_set2",    128'(o_set2),    128'(x2));
    check("issue_cnt", 128'(issue_cnt), 128'(pops));
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < pops; i++) void'(exp_q.pop_front());
      if (ready && (v == 2'b01 || v == 2'b11)) exp_q.push_back(a);
      if (ready && v == 2'b11) exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(2'b00, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_now();
    @(negedge clk);
    rstn     = 1'b0;
    in_valid = 2'b00;
    stall    = 1'b0;
    flush    = 1'b0;
    #1;
    exp_q.delete();
    check("rst_count",     128'(count),     128'(0));
    check("rst_in_ready",  128'(in_ready),  128'(1));
    check("rst_o_set1",    128'(o_set1),    128'(0));
    check("rst_o_set2",    128'(o_set2),    128'(0));
    check("rst_issue_cnt", 128'(issue_cnt), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn     = 1'b0;
    in_valid = 2'b00;
    in_set1  = '0;
    in_set2  = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    reset_now();

    // independent ALU pair issues together, then the queue drains
    step(2'b11, mk(1, 5'd1, 5'd2, 5'd3, 0, 0), mk(1, 5'd4, 5'd5, 5'd6, 0, 0), 1'b0, 1'b0);
    idle(2);

    // RAW hazard forces single issue
    step(2'b11, mk(1, 5'd5, 5'd1, 5'd2, 0, 0), mk(0, 5'd0, 5'd5, 5'd3, 0, 0), 1'b0, 1'b0);
    idle(3);

    // two loads, then a branch followed by an ALU op
    step(2'b11, mk(1, 5'd7, 5'd1, 5'd2, 3'd1, 0), mk(1, 5'd8, 5'd3, 5'd4, 3'd1, 0), 1'b0, 1'b0);
    idle(3);
    step(2'b11, mk(0, 5'd0, 5'd1, 5'd2, 0, 3'd1), mk(1, 5'd9, 5'd3, 5'd4, 0, 0), 1'b0, 1'b0);
    idle(3);

    // fill to 15 under stall; the further pair is refused
    for (int i = 0; i < 7; i++) step(2'b11, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    step(2'b01, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    step(2'b11, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    step(2'b10, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    step(2'b00, '0, '0, 1'b1, 1'b0);

    // flush at count 6 with a concurrent push
    step(2'b00, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b11, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    step(2'b11, rnd_pkt(), rnd_pkt(), 1'b1, 1'b1);
    idle(1);

    // random mixed traffic, wrapping the pointers many times
    for (int i = 0; i < 300; i++) begin
      logic [1:0] v;
      int         r;
      r = $urandom_range(0, 9);
      v = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b11 : 2'b10;
      step(v, rnd_pkt(), rnd_pkt(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 40) == 0));
    end

    // reset in the middle of activity
    for (int i = 0; i < 4; i++) step(2'b11, rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    reset_now();
    step(2'b01, rnd_pkt(), rnd_pkt(), 1'b0, 1'b0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
